// File: rtl/delay_sequencer.sv
// Chains a programmable number of delay-timer intervals into one long delay
// and reports completion or abort to the controller above it.
module delay_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             req,
    input  logic [CNT_W-1:0] num_intervals,
    input  logic             abort,
    input  logic             timerOF,
    output logic             timerstart,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {IDLE, RUN, RESTART, FINISH} state_t;

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO = '0;

    state_t state;
    logic   of_prev;
    logic   of_rise;

    // Only a fresh overflow edge counts, so a strobe held high across the
    // RESTART cycle is not counted a second time.
    assign of_rise = timerOF & ~of_prev;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            of_prev    <= 1'b0;
            timerstart <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            remaining  <= ZERO;
        end else begin
            of_prev <= timerOF;
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (num_intervals != ZERO) begin
                            state      <= RUN;
                            remaining  <= num_intervals;
                            timerstart <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state      <= IDLE;
                        timerstart <= 1'b0;
                        busy       <= 1'b0;
                        remaining  <= ZERO;
                        aborted    <= 1'b1;
                    end else if (of_rise) begin
                        remaining  <= remaining - ONE;
                        timerstart <= 1'b0;
                        if (remaining == ONE) begin
                            state <= FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RESTART;
                        end
                    end
                end
                RESTART: begin
                    if (abort) begin
                        state      <= IDLE;
                        timerstart <= 1'b0;
                        busy       <= 1'b0;
                        remaining  <= ZERO;
                        aborted    <= 1'b1;
                    end else begin
                        state      <= RUN;
                        timerstart <= 1'b1;
                    end
                end
                FINISH: begin
                    state      <= IDLE;
                    timerstart <= 1'b0;
                    busy       <= 1'b0;
                    remaining  <= ZERO;
                end
                default: begin
                    state      <= IDLE;
                    timerstart <= 1'b0;
                    busy       <= 1'b0;
                    remaining  <= ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_sequencer.sv
// Bench for delay_sequencer: timer model, transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_delay_sequencer;

    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             rst = 1'b0;
    logic             req = 1'b0;
    logic [CNT_W-1:0] num = '0;
    logic             abort = 1'b0;
    logic             tof = 1'b0;
    logic             ts, busy, done, aborted;
    logic [CNT_W-1:0] remaining;

    int checks = 0;
    int errors = 0;

    // timer model state
    int tper = 50;
    int tcnt = 0;
    int hold = 0;
    bit toggle_mode = 0;
    bit glitch_en = 0;

    // reference model: a sequence is either active (counting or clearing),
    // just finished, or absent
    bit m_active, m_gap, m_done, m_abt, m_prev;
    int m_rem;

    delay_sequencer #(.CNT_W(CNT_W)) dut (
        .clock(clock), .rst(rst), .req(req), .num_intervals(num),
        .abort(abort), .timerOF(tof), .timerstart(ts), .busy(busy),
        .done(done), .aborted(aborted), .remaining(remaining)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_gap = 0; m_done = 0; m_abt = 0; m_prev = 0; m_rem = 0;
    endtask

    task automatic model_step();
        bit rise, was_fin;
        if (!rst) begin
            model_reset();
            return;
        end
        rise = tof && !m_prev;
        m_prev = tof;
        was_fin = m_done;
        m_done = 0;
        m_abt = 0;
        if (was_fin) begin
        end else if (!m_active) begin
            if (req) begin
                if (num == 0) m_done = 1;
                else begin
                    m_active = 1; m_rem = int'(num); m_gap = 0;
                end
            end
        end else if (abort) begin
            m_active = 0; m_rem = 0; m_gap = 0; m_abt = 1;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (rise) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_active = 0; m_done = 1;
            end else m_gap = 1;
        end
    endtask

    // one clock: model follows the edge, outputs compared at the falling edge,
    // then the timer model produces the next overflow value
    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        chk("timerstart", int'(ts), int'(m_active && !m_gap));
        chk("busy", int'(busy), int'(m_active));
        chk("done", int'(done), int'(m_done));
        chk("aborted", int'(aborted), int'(m_abt));
        chk("remaining", int'(remaining), m_rem);
        if (toggle_mode) tof = ~tof;
        else begin
            if (ts) tcnt++; else tcnt = 0;
            tof = (hold > 0) || (tcnt == tper) || (glitch_en && $urandom_range(0, 39) == 0);
            if (hold > 0) hold--;
        end
    endtask

    task automatic start(input int n);
        num = CNT_W'(n);
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    initial begin
        int lat, hi, rises, dsum;
        bit prev_ts, seen;
        model_reset();

        // reset held with activity on the inputs
        req = 1'b1; num = 8'd5; toggle_mode = 1;
        repeat (6) tick();
        chk("rst_timerstart", int'(ts), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_remaining", int'(remaining), 0);
        req = 1'b0; toggle_mode = 0; tof = 1'b0;
        rst = 1'b1;
        tick();
        chk("post_rst_timerstart", int'(ts), 0);

        // single interval
        start(1);
        lat = 1; hi = 0; seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin seen = 1; break; end
            hi += int'(ts);
            tick();
            lat++;
        end
        chk("single_done_seen", int'(seen), 1);
        chk("single_latency", lat - 1, 50);
        chk("single_high_cycles", hi, 50);
        chk("single_busy_at_done", int'(busy), 0);
        tick();
        chk("single_done_width", int'(done), 0);
        tick();

        // three chained intervals
        start(3);
        lat = 0; hi = 0; rises = 0; prev_ts = 0; seen = 0; dsum = 0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin seen = 1; break; end
            hi += int'(ts);
            if (ts && !prev_ts) rises++;
            prev_ts = ts;
            tick();
            lat++;
        end
        chk("chain_done_seen", int'(seen), 1);
        chk("chain_latency", lat, 152);
        chk("chain_high_cycles", hi, 150);
        chk("chain_high_periods", rises, 3);
        for (int i = 0; i < 4; i++) begin dsum += int'(done); tick(); end
        chk("chain_done_count", dsum, 1);

        // zero request
        start(0);
        chk("zero_done", int'(done), 1);
        chk("zero_busy", int'(busy), 0);
        chk("zero_timerstart", int'(ts), 0);
        tick();
        chk("zero_done_width", int'(done), 0);
        tick();

        // abort colliding with the first overflow
        start(2);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (tof) begin seen = 1; break; end
            tick();
        end
        chk("abort_of_seen", int'(seen), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_pulse", int'(aborted), 1);
        chk("abort_remaining", int'(remaining), 0);
        chk("abort_timerstart", int'(ts), 0);
        dsum = 0;
        for (int i = 0; i < 5; i++) begin dsum += int'(done); tick(); end
        chk("abort_no_done", dsum, 0);

        // overflow held high for five cycles counts once
        start(2);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (tof) begin seen = 1; break; end
            tick();
        end
        chk("hold_of_seen", int'(seen), 1);
        hold = 4;
        repeat (5) tick();
        chk("hold_remaining", int'(remaining), 1);
        chk("hold_busy", int'(busy), 1);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin seen = 1; break; end
            tick();
        end
        chk("hold_done_seen", int'(seen), 1);
        repeat (2) tick();

        // req while busy is ignored
        start(3);
        repeat (5) tick();
        num = 8'd7; req = 1'b1;
        tick();
        req = 1'b0;
        chk("busy_req_remaining", int'(remaining), 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        // asynchronous reset in the middle of RUN
        start(2);
        repeat (10) tick();
        #2 rst = 1'b0;
        #1;
        chk("async_timerstart", int'(ts), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_remaining", int'(remaining), 0);
        model_reset();
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // randomized traffic
        tper = int'($urandom_range(3, 10));
        glitch_en = 1;
        for (int i = 0; i < 3000; i++) begin
            req = ($urandom_range(0, 3) == 0);
            num = CNT_W'($urandom_range(0, 4));
            abort = ($urandom_range(0, 59) == 0);
            tick();
        end
        req = 1'b0; abort = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
